// File: rtl/easyaxi_slv_pkg.sv
// easyaxi_slv_pkg
//   Shared easyaxi defines and the slave package.
//   The `AXI_* macros are the project-wide widths and encodings. They are
//   guarded so that another easyaxi block may define them first. The package
//   derives typed localparams from them and holds the captured-request record
//   and the beat address/response rules.
//   Optional feature macro used by this block: EASYAXI_SLV_ARBUF_EN.
//   No ports.

`ifndef EASYAXI_DEFINE_SV
`define EASYAXI_DEFINE_SV
`define AXI_ID_W        4
`define AXI_ADDR_W      16
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_DATA_W      32
`define AXI_RESP_W      2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_SIZE_1B     3'b000
`define AXI_SIZE_2B     3'b001
`define AXI_SIZE_4B     3'b010
`define AXI_SIZE_8B     3'b011
`define AXI_SIZE_16B    3'b100
`define AXI_SIZE_32B    3'b101
`define AXI_SIZE_64B    3'b110
`define AXI_SIZE_128B   3'b111
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_SLVERR 2'b10
`endif

package easyaxi_slv_pkg;

  localparam int ID_W    = `AXI_ID_W;
  localparam int ADDR_W  = `AXI_ADDR_W;
  localparam int LEN_W   = `AXI_LEN_W;
  localparam int SIZE_W  = `AXI_SIZE_W;
  localparam int BURST_W = `AXI_BURST_W;
  localparam int DATA_W  = `AXI_DATA_W;
  localparam int RESP_W  = `AXI_RESP_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_req_t;

  // Beat k address. Only INCR advances. WRAP and reserved bursts return an
  // error response, so they simply repeat the start address.
  // The sum wraps silently at the address width.
  function automatic logic [ADDR_W-1:0] beat_addr(input ar_req_t req,
                                                  input logic [LEN_W-1:0] cnt);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(cnt) << req.size;
    beat_addr = (req.burst == `AXI_BURST_INCR) ? req.addr + off : req.addr;
  endfunction

  function automatic logic beat_slverr(input ar_req_t req);
    logic bad_burst;
    logic bad_size;
    bad_burst = (req.burst != `AXI_BURST_FIXED) && (req.burst != `AXI_BURST_INCR);
    bad_size  = (32'd1 << req.size) > 32'(DATA_W / 8);
    beat_slverr = bad_burst | bad_size;
  endfunction

endpackage

// File: rtl/easyaxi_slv_arbuf.sv
// easyaxi_slv_arbuf
//   Two-entry AR request FIFO. It is only built when EASYAXI_SLV_ARBUF_EN is
//   defined. The user never pushes when full and never pops when empty,
//   because arready and the pop condition are both derived from these flags.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_push, i_data     write one request
//   i_pop              drop the head entry
//   o_data             head entry (valid when !o_empty)
//   o_full, o_empty    occupancy flags

`ifdef EASYAXI_SLV_ARBUF_EN
module easyaxi_slv_arbuf
  import easyaxi_slv_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_push,
  input  ar_req_t i_data,
  input  logic    i_pop,
  output ar_req_t o_data,
  output logic    o_full,
  output logic    o_empty
);

  ar_req_t    r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule
`endif

// File: rtl/easyaxi_slv.sv
// easyaxi_slv
//   AXI read-only slave burst engine. It accepts AR requests and returns
//   len+1 R beats. Each beat's data is the beat address, zero-extended.
//   Optional EASYAXI_SLV_ARBUF_EN adds a 2-entry AR FIFO. With it, a new
//   burst can start on the cycle after the previous rlast beat, with no gap.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   axi_slv_ar*                   AR channel (valid/ready, id, addr, len, size, burst)
//   axi_slv_r*                    R channel  (valid/ready, id, data, resp, last)
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no burst active; ready to load a request
// ST_DATA | presenting beat r_cnt of the captured request on R

module easyaxi_slv
  import easyaxi_slv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_slv_arvalid,
  output logic                    axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]  axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]   axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0] axi_slv_arburst,
  output logic                    axi_slv_rvalid,
  input  logic                    axi_slv_rready,
  output logic [`AXI_ID_W-1:0]    axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]  axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                    axi_slv_rlast
);

  state_e           r_state;
  state_e           w_state_nxt;
  ar_req_t          r_req;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  ar_req_t          w_ar_in;
  ar_req_t          w_load_req;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_last;
  logic             w_can_load;
  logic             w_load;

  assign w_ar_in    = {axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
                       axi_slv_arsize, axi_slv_arburst};
  assign w_ar_hs    = axi_slv_arvalid & axi_slv_arready;
  assign w_r_hs     = axi_slv_rvalid & axi_slv_rready;
  assign w_last     = (r_cnt == r_req.len);
  // The engine can take a new request when idle, or when the last beat is
  // accepted this cycle.
  assign w_can_load = (r_state == ST_IDLE) | (w_r_hs & w_last);

`ifdef EASYAXI_SLV_ARBUF_EN
  logic    w_fifo_push;
  logic    w_fifo_pop;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  ar_req_t w_fifo_head;

  // An empty FIFO is bypassed. This keeps the one-cycle AR-to-beat-0
  // latency when idle. Queued requests always go first, to keep order.
  assign w_fifo_pop  = w_can_load & ~w_fifo_empty;
  assign w_fifo_push = w_ar_hs & ~(w_can_load & w_fifo_empty);
  assign w_load      = w_can_load & (~w_fifo_empty | w_ar_hs);
  assign w_load_req  = w_fifo_empty ? w_ar_in : w_fifo_head;
  assign axi_slv_arready = ~w_fifo_full;

  easyaxi_slv_arbuf u_arbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_data  (w_ar_in),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );
`else
  // arready is high only in IDLE, so a handshake always lands in IDLE.
  assign w_load          = w_can_load & w_ar_hs;
  assign w_load_req      = w_ar_in;
  assign axi_slv_arready = (r_state == ST_IDLE);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_r_hs) begin
          if (w_last) begin
            w_state_nxt = w_load ? ST_DATA : ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + LEN_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_req <= w_load_req;
    end
  end

  // The payload is a function of registered state only. It stays stable
  // while rready is low.
  assign axi_slv_rvalid = (r_state == ST_DATA);
  assign axi_slv_rid    = r_req.id;
  assign axi_slv_rdata  = DATA_W'(beat_addr(r_req, r_cnt));
  assign axi_slv_rresp  = beat_slverr(r_req) ? `AXI_RESP_SLVERR : `AXI_RESP_OKAY;
  // Gate with rvalid: the reset values make cnt == len.
  assign axi_slv_rlast  = axi_slv_rvalid & w_last;

endmodule

// File: tb/tb_easyaxi_slv.sv
`timescale 1ns/1ps
module tb_easyaxi_slv;
  import easyaxi_slv_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               arvalid = 1'b0;
  logic               arready;
  logic [ID_W-1:0]    arid = '0;
  logic [ADDR_W-1:0]  araddr = '0;
  logic [LEN_W-1:0]   arlen = '0;
  logic [SIZE_W-1:0]  arsize = '0;
  logic [BURST_W-1:0] arburst = '0;
  logic               rvalid;
  logic               rready = 1'b0;
  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  easyaxi_slv dut (
    .clk(clk), .rst_n(rst_n),
    .axi_slv_arvalid(arvalid), .axi_slv_arready(arready),
    .axi_slv_arid(arid), .axi_slv_araddr(araddr), .axi_slv_arlen(arlen),
    .axi_slv_arsize(arsize), .axi_slv_arburst(arburst),
    .axi_slv_rvalid(rvalid), .axi_slv_rready(rready),
    .axi_slv_rid(rid), .axi_slv_rdata(rdata), .axi_slv_rresp(rresp),
    .axi_slv_rlast(rlast)
  );

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  typedef struct {
    req_t        req;
    int          mode;       // 0 rready=1, 1 random, 2 pattern 1,0,0,1,1,0,1
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [1:0]  exp_resp;
    bit          chk_data;
  } vec_t;

  function automatic req_t mkr(input int id, input int addr, input int len,
                               input int size, input int burst);
    req_t r;
    r.id = 4'(id); r.addr = 16'(addr); r.len = 8'(len);
    r.size = 3'(size); r.burst = 2'(burst);
    return r;
  endfunction

  function automatic vec_t mkv(input req_t r, input int mode, input int nb,
                               input int first, input int last, input int resp,
                               input bit cd);
    vec_t v;
    v.req = r; v.mode = mode; v.exp_beats = nb;
    v.exp_first = 32'(first); v.exp_last = 32'(last);
    v.exp_resp = 2'(resp); v.chk_data = cd;
    return v;
  endfunction

  // Reference model: beat addresses come from plain integer arithmetic.
  function automatic logic [31:0] m_addr(input req_t q, input int k);
    int a;
    if (q.burst == 2'd0) return 32'(q.addr);
    a = (int'(q.addr) + k * (1 << int'(q.size))) % (1 << ADDR_W);
    return 32'(a);
  endfunction

  function automatic logic [1:0] m_resp(input req_t q);
    if (q.burst > 2'd1 || (1 << int'(q.size)) > DATA_W / 8) return 2'd2;
    return 2'd0;
  endfunction

  task automatic send_ar(input req_t q);
    int n;
    n = 0;
    @(negedge clk);
    arvalid = 1'b1; arid = q.id; araddr = q.addr; arlen = q.len;
    arsize = q.size; arburst = q.burst;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Called on the negedge after the AR handshake. Beat 0 must already be valid.
  task automatic collect(input req_t q, input int mode, output int nb,
                         output logic [31:0] first, output logic [31:0] last,
                         output logic [1:0] resp0);
    int k, guard, pi;
    logic [31:0] hold_d;
    logic hold_v;
    logic [6:0] pat;
    pat = 7'b1011001;
    k = 0; guard = 0; pi = 0; hold_v = 1'b0; hold_d = '0;
    nb = 0; first = '0; last = '0; resp0 = '0;
    while (k <= int'(q.len) && guard < 3000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: begin rready = pat[pi % 7]; pi++; end
      endcase
      chk("rvalid_in_burst", 32'(rvalid), 32'd1);
      if (rvalid) begin
        chk("rid", 32'(rid), 32'(q.id));
        if (q.burst <= 2'd1) chk("rdata", rdata, m_addr(q, k));
        chk("rresp", 32'(rresp), 32'(m_resp(q)));
        chk("rlast", 32'(rlast), (k == int'(q.len)) ? 32'd1 : 32'd0);
        if (hold_v) chk("hold_rdata", rdata, hold_d);
        if (k == 0) begin first = rdata; resp0 = rresp; end
        if (rready) begin
          last = rdata; k++; nb++; hold_v = 1'b0;
        end else begin
          hold_v = 1'b1; hold_d = rdata;
        end
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk("beat_timeout", 32'd0, 32'd1);
    rready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int nb;
    logic [31:0] f, l;
    logic [1:0] r0;
    req_t q;

    vecs.push_back(mkv(mkr(1, 'h0000, 3, 2, 1), 0, 4, 'h0, 'hC, 0, 1));
    vecs.push_back(mkv(mkr(1, 'h0000, 3, 2, 1), 2, 4, 'h0, 'hC, 0, 1));
    vecs.push_back(mkv(mkr(5, 'h0001, 0, 0, 0), 0, 1, 'h1, 'h1, 0, 1));
    vecs.push_back(mkv(mkr(6, 'h0010, 1, 2, 2), 0, 2, 0, 0, 2, 0));
    vecs.push_back(mkv(mkr(7, 'hFFFC, 1, 2, 1), 0, 2, 'hFFFC, 'h0000, 0, 1));
    vecs.push_back(mkv(mkr(8, 'h0100, 2, 3, 1), 0, 3, 'h100, 'h110, 2, 1));
    vecs.push_back(mkv(mkr(9, 'h0000, 255, 0, 1), 0, 256, 'h0, 'hFF, 0, 1));
    vecs.push_back(mkv(mkr(3, 'h0020, 3, 1, 0), 2, 4, 'h20, 'h20, 0, 1));

    // Reset values while rst_n is low.
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send_ar(vecs[i].req);
      collect(vecs[i].req, vecs[i].mode, nb, f, l, r0);
      chk($sformatf("v%0d_beats", i), 32'(nb), 32'(vecs[i].exp_beats));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_first", i), f, vecs[i].exp_first);
        chk($sformatf("v%0d_last", i), l, vecs[i].exp_last);
      end
      chk($sformatf("v%0d_resp", i), 32'(r0), 32'(vecs[i].exp_resp));
      chk($sformatf("v%0d_rvalid_drop", i), 32'(rvalid), 32'd0);
      chk($sformatf("v%0d_arready_back", i), 32'(arready), 32'd1);
    end

    // Randomized bursts against the model.
    for (int t = 0; t < 30; t++) begin
      q = mkr(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
      send_ar(q);
      collect(q, 1, nb, f, l, r0);
      chk("rand_beats", 32'(nb), 32'(int'(q.len) + 1));
      chk("rand_rvalid_drop", 32'(rvalid), 32'd0);
    end

    // Reset asserted on beat 2 of a len=7 burst.
    q = mkr(10, 'h0040, 7, 2, 1);
    send_ar(q);
    rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_beat2_rdata", rdata, 32'h48);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    chk("mid_rst_rlast", 32'(rlast), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_no_beat", 32'(rvalid), 32'd0);
    end
    rready = 1'b0;

`ifdef EASYAXI_SLV_ARBUF_EN
    begin
      int rids[$];
      int cyc[$];
      int dat[$];
      int lst[$];
      @(negedge clk);
      rready = 1'b1;
      for (int c = 0; c < 30; c++) begin
        if (c < 3) begin
          arvalid = 1'b1; arid = 4'(2 + c); araddr = '0; arlen = 8'd3;
          arsize = 3'd2; arburst = 2'd1;
          chk("buf_arready_open", 32'(arready), 32'd1);
        end else begin
          arvalid = 1'b0;
        end
        if (c == 3) chk("buf_arready_full", 32'(arready), 32'd0);
        if (rvalid) begin
          rids.push_back(int'(rid)); cyc.push_back(c);
          dat.push_back(int'(rdata)); lst.push_back(int'(rlast));
        end
        @(negedge clk);
      end
      rready = 1'b0;
      chk("buf_beats", 32'(rids.size()), 32'd12);
      if (rids.size() == 12) begin
        for (int i = 0; i < 12; i++) begin
          chk("buf_rid", 32'(rids[i]), 32'(2 + i / 4));
          chk("buf_contig", 32'(cyc[i]), 32'(cyc[0] + i));
          chk("buf_rdata", 32'(dat[i]), 32'((i % 4) * 4));
          chk("buf_rlast", 32'(lst[i]), (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        chk("buf_first_cycle", 32'(cyc[0]), 32'd1);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
